// File: rtl/pump_ctrl_fsm.sv
// Flood-drain pump controller: PRIME warning, min/max run, min off, latched fault.
// Optional manual override when PUMP_MANUAL_EN is defined (adds the manual_on port).
module pump_ctrl_fsm #(
  parameter int LW        = 8,
  parameter int TW        = 8,
  parameter int HIGH_TH   = 200,
  parameter int LOW_TH    = 80,
  parameter int START_DLY = 3,
  parameter int MIN_RUN   = 10,
  parameter int MAX_RUN   = 120,
  parameter int MIN_OFF   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [LW-1:0] level,
  input  logic          fault_ack,
`ifdef PUMP_MANUAL_EN
  input  logic          manual_on,
`endif
  output logic          pump_on,
  output logic          warn,
  output logic          alarm,
  output logic [2:0]    state,
  output logic [TW-1:0] run_sec
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    RUN   = 3'd2,
    COOL  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [LW-1:0] HIGH_L     = LW'(HIGH_TH);
  localparam logic [LW-1:0] LOW_L      = LW'(LOW_TH);
  localparam logic [TW-1:0] START_LAST = TW'(START_DLY - 1);
  localparam logic [TW-1:0] MIN_RUN_L  = TW'(MIN_RUN);
  localparam logic [TW-1:0] MAX_LAST   = TW'(MAX_RUN - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(MIN_OFF - 1);

  logic [2:0]    state_q;
  state_t        state_d;
  logic [TW-1:0] tmr_q;
  logic [TW-1:0] tmr_d;
  logic          man;

`ifdef PUMP_MANUAL_EN
  assign man = manual_on;
`else
  assign man = 1'b0;
`endif

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (man)                  state_d = RUN;
        else if (level >= HIGH_L) state_d = PRIME;
        else                      state_d = IDLE;
      end
      PRIME: begin
        if (level < LOW_L)                     state_d = IDLE;
        else if (tick && tmr_q == START_LAST) state_d = RUN;
        else                                   state_d = PRIME;
      end
      RUN: begin
        // The max-run fault wins over a normal stop on the same cycle.
        if (tick && tmr_q == MAX_LAST)                          state_d = FAULT;
        else if (!man && level <= LOW_L && tmr_q >= MIN_RUN_L) state_d = COOL;
        else                                                    state_d = RUN;
      end
      COOL: begin
        if (tick && tmr_q == OFF_LAST) state_d = IDLE;
        else                           state_d = COOL;
      end
      FAULT: begin
        if (fault_ack && level < HIGH_L) state_d = IDLE;
        else                             state_d = FAULT;
      end
      default: state_d = IDLE;
    endcase

    // Timer restarts on any state change and saturates at all-ones.
    if (state_q != 3'(state_d))          tmr_d = '0;
    else if (tick && tmr_q != {TW{1'b1}}) tmr_d = tmr_q + 1'b1;
    else                                  tmr_d = tmr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 3'(IDLE);
      tmr_q   <= '0;
      pump_on <= 1'b0;
      warn    <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_q <= 3'(state_d);
      tmr_q   <= tmr_d;
      pump_on <= (state_d == RUN);
      warn    <= (state_d == PRIME);
      alarm   <= (state_d == FAULT);
    end
  end

  assign state   = state_q;
  assign run_sec = tmr_q;

endmodule

// File: tb/tb_pump_ctrl_fsm.sv
// Bench for pump_ctrl_fsm: directed scenarios plus random stimulus against a rule-level model.
module tb_pump_ctrl_fsm;

  localparam int HIGH_TH = 200, LOW_TH = 80, START_DLY = 3, MIN_RUN = 4, MAX_RUN = 8, MIN_OFF = 2;
`ifdef PUMP_MANUAL_EN
  localparam bit MANUAL = 1'b1;
`else
  localparam bit MANUAL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] level = 8'd0;
  logic       fault_ack = 1'b0;
  logic       manual_on = 1'b0;
  logic       pump_on, warn, alarm;
  logic [2:0] state;
  logic [7:0] run_sec;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_mode = 0;
  int m_sec = 0;

  pump_ctrl_fsm #(
    .LW(8), .TW(8), .HIGH_TH(HIGH_TH), .LOW_TH(LOW_TH), .START_DLY(START_DLY),
    .MIN_RUN(MIN_RUN), .MAX_RUN(MAX_RUN), .MIN_OFF(MIN_OFF)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .level(level), .fault_ack(fault_ack),
`ifdef PUMP_MANUAL_EN
    .manual_on(manual_on),
`endif
    .pump_on(pump_on), .warn(warn), .alarm(alarm), .state(state), .run_sec(run_sec)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model: mode numbers are the published state codes, m_sec is seconds spent in that mode.
  task automatic model_step(input logic tk, input int lv, input logic ack, input logic man);
    int nm;
    bit m;
    m  = MANUAL && man;
    nm = m_mode;
    if (m_mode == 0) begin
      if (m) nm = 2;
      else if (lv >= HIGH_TH) nm = 1;
    end else if (m_mode == 1) begin
      if (lv < LOW_TH) nm = 0;
      else if (tk && m_sec + 1 == START_DLY) nm = 2;
    end else if (m_mode == 2) begin
      if (tk && m_sec + 1 == MAX_RUN) nm = 4;
      else if (!m && lv <= LOW_TH && m_sec >= MIN_RUN) nm = 3;
    end else if (m_mode == 3) begin
      if (tk && m_sec + 1 == MIN_OFF) nm = 0;
    end else begin
      if (ack && lv < HIGH_TH) nm = 0;
    end
    if (nm != m_mode) m_sec = 0;
    else if (tk && m_sec < 255) m_sec++;
    m_mode = nm;
  endtask

  task automatic step(input logic tk, input int lv, input logic ack, input logic man);
    @(negedge clk);
    tick = tk; level = 8'(lv); fault_ack = ack; manual_on = man;
    model_step(tk, lv, ack, man);
    @(posedge clk);
    #1;
    chk("state", 32'(state), 32'(m_mode));
    chk("pump_on", 32'(pump_on), 32'(m_mode == 2));
    chk("warn", 32'(warn), 32'(m_mode == 1));
    chk("alarm", 32'(alarm), 32'(m_mode == 4));
    chk("run_sec", 32'(run_sec), 32'(m_sec));
  endtask

  // Directed steps: tick high one cycle in four.
  task automatic dstep(input int lv, input logic ack, input logic man);
    step(cyc % 4 == 3, lv, ack, man);
    cyc++;
  endtask

  task automatic wait_state(input string tag, input int target, input int lv, input int budget);
    int n = 0;
    while (state !== 3'(target) && n < budget) begin
      dstep(lv, 1'b0, 1'b0);
      n++;
    end
    chk(tag, 32'(state), 32'(target));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", {29'd0, pump_on, warn, alarm}, 0);
    chk("rst_sec", 32'(run_sec), 0);
    @(negedge clk);
    rst = 1'b0;
    m_mode = 0; m_sec = 0; cyc = 0;

    // Test 1: high water, PRIME, RUN on 3rd tick
    dstep(210, 1'b0, 1'b0);
    chk("t1_prime", 32'(state), 1);
    chk("t1_warn", 32'(warn), 1);
    wait_state("t1_run", 2, 210, 20);
    chk("t1_pump", 32'(pump_on), 1);
    chk("t1_warn_off", 32'(warn), 0);

    // Test 2: low water after 2 ticks, pump held to MIN_RUN, then COOL then IDLE
    for (int n = 0; n < 20 && m_sec < 2; n++) dstep(150, 1'b0, 1'b0);
    chk("t2_sec2", 32'(run_sec), 2);
    wait_state("t2_cool", 3, 50, 20);
    chk("t2_pump_off", 32'(pump_on), 0);
    wait_state("t2_idle", 0, 50, 20);

    // Test 3: sustained high water runs into FAULT; ack ignored while still high
    wait_state("t3_run", 2, 210, 30);
    wait_state("t3_fault", 4, 210, 60);
    chk("t3_alarm", 32'(alarm), 1);
    chk("t3_pump", 32'(pump_on), 0);
    repeat (6) dstep(210, 1'b1, 1'b0);
    chk("t3_hold", 32'(state), 4);
    dstep(100, 1'b1, 1'b0);
    chk("t3_clear", 32'(state), 0);
    chk("t3_alarm_off", 32'(alarm), 0);

    // Test 4: abort PRIME when level falls below LOW_TH
    dstep(210, 1'b0, 1'b0);
    chk("t4_prime", 32'(state), 1);
    for (int n = 0; n < 10 && m_sec < 1; n++) dstep(210, 1'b0, 1'b0);
    dstep(70, 1'b0, 1'b0);
    chk("t4_abort", 32'(state), 0);
    repeat (12) begin
      dstep(70, 1'b0, 1'b0);
      chk("t4_no_pump", 32'(pump_on), 0);
    end

    // Test 5: asynchronous reset mid-RUN with run_sec=5
    wait_state("t5_run", 2, 210, 30);
    for (int n = 0; n < 40 && !(m_mode == 2 && m_sec == 5); n++) dstep(150, 1'b0, 1'b0);
    chk("t5_sec5", 32'(run_sec), 5);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_pump", 32'(pump_on), 0);
    chk("t5_async_state", 32'(state), 0);
    chk("t5_async_sec", 32'(run_sec), 0);
    m_mode = 0; m_sec = 0;
    @(negedge clk);
    rst = 1'b0;
    dstep(210, 1'b0, 1'b0);
    chk("t5_restart", 32'(state), 1);
    wait_state("t5_run2", 2, 210, 20);
    wait_state("t5_cool", 3, 20, 20);
    wait_state("t5_idle", 0, 20, 20);

`ifdef PUMP_MANUAL_EN
    // Test 6: manual start from IDLE with dry sump, held until MAX_RUN fault
    dstep(0, 1'b0, 1'b1);
    chk("t6_run", 32'(state), 2);
    chk("t6_pump", 32'(pump_on), 1);
    for (int n = 0; n < 60 && state === 3'd2; n++) dstep(0, 1'b0, 1'b1);
    chk("t6_fault", 32'(state), 4);
    dstep(0, 1'b1, 1'b0);
    chk("t6_clear", 32'(state), 0);
`endif

    // Random phase: level bands around the thresholds, sparse ticks, ack and manual requests
    for (int n = 0; n < 3000; n++) begin
      int lv;
      case ($urandom_range(0, 3))
        0:       lv = $urandom_range(200, 255);
        1:       lv = $urandom_range(0, 80);
        2:       lv = $urandom_range(79, 201);
        default: lv = $urandom_range(0, 255);
      endcase
      step($urandom_range(0, 3) == 0, lv, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
